// File: rtl/puck_pkg.sv
// Shared types and widths for the puck game core.
// Coordinates are unsigned 10-bit; next-position arithmetic runs in 12-bit signed.
package puck_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned WORK_W  = 12;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        MISS  = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    typedef logic [COORD_W-1:0]       coord_t;
    typedef logic signed [WORK_W-1:0] work_t;

    function automatic work_t widen(input coord_t c);
        return work_t'({{(WORK_W-COORD_W){1'b0}}, c});
    endfunction

endpackage

// File: rtl/puck_axis.sv
// One-axis stepper: moves a coordinate by +/-SPEED, clamps against the walls
// and optionally reflects the direction when a wall is struck.
module puck_axis
    import puck_pkg::*;
#(
    parameter int SPEED    = 2,
    parameter int HI       = 472,
    parameter bit CLAMP_LO = 1'b1,
    parameter bit FLIP     = 1'b1
) (
    input  logic                en,
    input  logic [COORD_W-1:0]  pos,
    input  dir_t                dir,
    output logic [WORK_W-1:0]   raw,
    output logic [COORD_W-1:0]  next_pos,
    output dir_t                next_dir
);

    work_t step;
    work_t sum;
    logic  below_lo;
    logic  above_hi;

    always_comb begin
        step     = (dir == DIR_NEG) ? -work_t'(SPEED) : work_t'(SPEED);
        sum      = widen(pos) + step;
        below_lo = sum[WORK_W-1];
        above_hi = sum > work_t'(HI);
        raw      = sum;

        next_pos = pos;
        next_dir = dir;
        if (en) begin
            next_pos = sum[COORD_W-1:0];
            if (above_hi) begin
                next_pos = coord_t'(HI);
                if (FLIP) next_dir = DIR_NEG;
            end else if (below_lo && CLAMP_LO) begin
                next_pos = '0;
                if (FLIP) next_dir = DIR_POS;
            end
        end
    end

endmodule

// File: rtl/puck_engine.sv
// Per-frame game state for the single-paddle puck game: paddle, ball,
// score, lives and phase, all advanced on the vblank frame_tick pulse.
module puck_engine
    import puck_pkg::*;
#(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int BALL_SIZE    = 8,
    parameter int PAD_X        = 32,
    parameter int PAD_W        = 4,
    parameter int PAD_H        = 64,
    parameter int BALL_SPEED   = 2,
    parameter int PAD_SPEED    = 3,
    parameter int SCORE_W      = 16,
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               up,
    input  logic               down,
    input  logic               start,
    output logic [9:0]         pad_y,
    output logic [9:0]         ball_x,
    output logic [9:0]         ball_y,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         lives,
    output logic [1:0]         state,
    output logic               hit
);

    localparam int PAD_MAX = V_RES - PAD_H;
    localparam int BX_MAX  = H_RES - BALL_SIZE;
    localparam int BY_MAX  = V_RES - BALL_SIZE;
    localparam coord_t PAD_Y0  = coord_t'(PAD_MAX / 2);
    localparam coord_t BALL_X0 = coord_t'(BX_MAX / 2);
    localparam coord_t BALL_Y0 = coord_t'(BY_MAX / 2);
    localparam int unsigned CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

    game_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    coord_t             pad_q, pad_d;
    coord_t             bx_q, bx_d;
    coord_t             by_q, by_d;
    dir_t               dx_q, dx_d;
    dir_t               dy_q, dy_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         lives_q, lives_d;
    logic               hit_q, hit_d;

    work_t  nx, ny;
    coord_t ax_pos, ay_pos, pad_next;
    dir_t   ax_dir, ay_dir;
    work_t  pad_raw_unused;
    dir_t   pad_dir_unused;
    logic   collide;
    logic   miss;

    // Left edge is open: the paddle/miss logic owns it, so no low clamp on x.
    puck_axis #(.SPEED(BALL_SPEED), .HI(BX_MAX), .CLAMP_LO(1'b0), .FLIP(1'b1)) u_axis_x (
        .en       (1'b1),
        .pos      (bx_q),
        .dir      (dx_q),
        .raw      (nx),
        .next_pos (ax_pos),
        .next_dir (ax_dir)
    );

    puck_axis #(.SPEED(BALL_SPEED), .HI(BY_MAX), .CLAMP_LO(1'b1), .FLIP(1'b1)) u_axis_y (
        .en       (1'b1),
        .pos      (by_q),
        .dir      (dy_q),
        .raw      (ny),
        .next_pos (ay_pos),
        .next_dir (ay_dir)
    );

    puck_axis #(.SPEED(PAD_SPEED), .HI(PAD_MAX), .CLAMP_LO(1'b1), .FLIP(1'b0)) u_axis_pad (
        .en       (up ^ down),
        .pos      (pad_q),
        .dir      (up ? DIR_NEG : DIR_POS),
        .raw      (pad_raw_unused),
        .next_pos (pad_next),
        .next_dir (pad_dir_unused)
    );

    always_comb begin
        collide = (dx_q == DIR_NEG)
               && (nx <= work_t'(PAD_X + PAD_W - 1))
               && (nx + work_t'(BALL_SIZE) > work_t'(PAD_X))
               && (ny + work_t'(BALL_SIZE) > widen(pad_q))
               && (ny < widen(pad_q) + work_t'(PAD_H));
        miss = nx[WORK_W-1];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pad_d   = pad_q;
        bx_d    = bx_q;
        by_d    = by_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        score_d = score_q;
        lives_d = lives_q;
        hit_d   = 1'b0;

        if (frame_tick) begin
            if (state_q != OVER) pad_d = pad_next;

            case (state_q)
                SERVE: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = PLAY;
                        dx_d    = DIR_NEG;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PLAY: begin
                    // Collision wins over miss; a miss freezes the ball on both axes.
                    if (miss && !collide) begin
                        lives_d = lives_q - 3'd1;
                        state_d = (lives_q == 3'd1) ? OVER : MISS;
                    end else begin
                        by_d = ay_pos;
                        dy_d = ay_dir;
                        if (collide) begin
                            bx_d    = coord_t'(PAD_X + PAD_W);
                            dx_d    = DIR_POS;
                            score_d = (score_q == '1) ? score_q : score_q + 1'b1;
                            hit_d   = 1'b1;
                        end else begin
                            bx_d = ax_pos;
                            dx_d = ax_dir;
                        end
                    end
                end
                MISS: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = SERVE;
                        bx_d    = BALL_X0;
                        by_d    = BALL_Y0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                OVER: begin
                    if (start) begin
                        score_d = '0;
                        lives_d = 3'(LIVES);
                        bx_d    = BALL_X0;
                        by_d    = BALL_Y0;
                        pad_d   = PAD_Y0;
                        cnt_d   = '0;
                        state_d = SERVE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SERVE;
            cnt_q   <= '0;
            pad_q   <= PAD_Y0;
            bx_q    <= BALL_X0;
            by_q    <= BALL_Y0;
            dx_q    <= DIR_NEG;
            dy_q    <= DIR_POS;
            score_q <= '0;
            lives_q <= 3'(LIVES);
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pad_q   <= pad_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            score_q <= score_d;
            lives_q <= lives_d;
            hit_q   <= hit_d;
        end
    end

    assign pad_y  = pad_q;
    assign ball_x = bx_q;
    assign ball_y = by_q;
    assign score  = score_q;
    assign lives  = lives_q;
    assign state  = state_q;
    assign hit    = hit_q;

endmodule

// File: tb/tb_puck_engine.sv
// Directed bench for puck_engine with a frame-level game model checked every cycle.
module tb_puck_engine;

    localparam int H_RES = 640, V_RES = 480, BALL_SIZE = 8;
    localparam int PAD_X = 32, PAD_W = 4, PAD_H = 64;
    localparam int BALL_SPEED = 2, PAD_SPEED = 3, LIVES = 3, SERVE_FRAMES = 60;
    localparam int BX_MAX = H_RES - BALL_SIZE, BY_MAX = V_RES - BALL_SIZE;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_tick = 1'b0;
    logic        up = 1'b0, down = 1'b0, start = 1'b0;
    logic [9:0]  pad_y, ball_x, ball_y;
    logic [15:0] score;
    logic [2:0]  lives;
    logic [1:0]  state;
    logic        hit;
    logic [9:0]  s_pad_y, s_ball_x, s_ball_y;
    logic [1:0]  s_score;
    logic [2:0]  s_lives;
    logic [1:0]  s_state;
    logic        s_hit;

    puck_engine dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .up(up), .down(down), .start(start),
        .pad_y(pad_y), .ball_x(ball_x), .ball_y(ball_y), .score(score), .lives(lives),
        .state(state), .hit(hit)
    );

    puck_engine #(.SCORE_W(2)) dut_sat (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .up(up), .down(down), .start(start),
        .pad_y(s_pad_y), .ball_x(s_ball_x), .ball_y(s_ball_y), .score(s_score), .lives(s_lives),
        .state(s_state), .hit(s_hit)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    bit check_en = 1'b0;
    logic last_hit;

    // Model state: plain integers, directions as +1/-1, state as 0..3.
    int m_pad, m_bx, m_by, m_dx, m_dy, m_hits, m_lives, m_state, m_cnt, m_hit;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    function automatic void model_reset();
        m_pad = (V_RES - PAD_H) / 2; m_bx = BX_MAX / 2; m_by = BY_MAX / 2;
        m_dx = -1; m_dy = 1; m_hits = 0; m_lives = LIVES; m_state = 0; m_cnt = 0; m_hit = 0;
    endfunction

    function automatic void model_step(input bit u, input bit d, input bit s);
        int old_pad, nx, ny;
        bit col;
        old_pad = m_pad;
        if (m_state != 3) begin
            if (u && !d)      m_pad = (m_pad - PAD_SPEED < 0) ? 0 : m_pad - PAD_SPEED;
            else if (d && !u) m_pad = (m_pad + PAD_SPEED > V_RES - PAD_H) ? V_RES - PAD_H : m_pad + PAD_SPEED;
        end
        case (m_state)
            0: if (m_cnt == SERVE_FRAMES - 1) begin m_cnt = 0; m_state = 1; m_dx = -1; end
               else m_cnt++;
            1: begin
                nx = m_bx + m_dx * BALL_SPEED;
                ny = m_by + m_dy * BALL_SPEED;
                col = (m_dx == -1) && (nx <= PAD_X + PAD_W - 1) && (nx + BALL_SIZE > PAD_X)
                      && (ny + BALL_SIZE > old_pad) && (ny < old_pad + PAD_H);
                if (!col && nx < 0) begin
                    m_lives--;
                    m_state = (m_lives == 0) ? 3 : 2;
                end else begin
                    if (ny < 0)           begin m_by = 0;      m_dy = 1;  end
                    else if (ny > BY_MAX) begin m_by = BY_MAX; m_dy = -1; end
                    else m_by = ny;
                    if (col)              begin m_bx = PAD_X + PAD_W; m_dx = 1; m_hits++; m_hit = 1; end
                    else if (nx > BX_MAX) begin m_bx = BX_MAX; m_dx = -1; end
                    else m_bx = nx;
                end
            end
            2: if (m_cnt == SERVE_FRAMES - 1) begin
                   m_cnt = 0; m_state = 0; m_bx = BX_MAX / 2; m_by = BY_MAX / 2;
               end else m_cnt++;
            default: if (s) begin
                m_hits = 0; m_lives = LIVES; m_bx = BX_MAX / 2; m_by = BY_MAX / 2;
                m_pad = (V_RES - PAD_H) / 2; m_cnt = 0; m_state = 0;
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (check_en && reset) begin
            chk("pad_y",  pad_y,  m_pad);
            chk("ball_x", ball_x, m_bx);
            chk("ball_y", ball_y, m_by);
            chk("score",  score,  (m_hits > 65535) ? 65535 : m_hits);
            chk("lives",  lives,  m_lives);
            chk("state",  state,  m_state);
            chk("hit",    hit,    m_hit);
            chk("sat_score", s_score, (m_hits > 3) ? 3 : m_hits);
            chk("sat_state", s_state, m_state);
        end
    end

    task automatic do_tick(input logic u, input logic d, input logic s);
        @(negedge clk);
        up = u; down = d; start = s; frame_tick = 1'b1;
        @(posedge clk);
        model_step(u, d, s);
        @(negedge clk);
        last_hit = hit;
        frame_tick = 1'b0; up = 1'b0; down = 1'b0; start = 1'b0;
        @(posedge clk);
        m_hit = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pad"},   pad_y,  208);
        chk({tag, "_bx"},    ball_x, 316);
        chk({tag, "_by"},    ball_y, 236);
        chk({tag, "_score"}, score,  0);
        chk({tag, "_lives"}, lives,  3);
        chk({tag, "_state"}, state,  0);
        chk({tag, "_hit"},   hit,    0);
    endtask

    initial begin
        int guard, target, prev_hits, prev_state, misses, pad_before;

        // frame_tick pulses while reset is held must not move anything
        model_reset();
        frame_tick = 1'b1;
        repeat (4) @(posedge clk);
        #1 check_reset_values("reset");
        @(negedge clk);
        frame_tick = 1'b0;
        reset = 1'b1;
        check_en = 1'b1;

        repeat (SERVE_FRAMES - 1) do_tick(0, 0, 0);
        chk("serve_hold_state", state, 0);
        chk("serve_hold_bx", ball_x, 316);
        chk("serve_hold_by", ball_y, 236);
        do_tick(0, 0, 0);
        chk("launch_state", state, 1);
        do_tick(0, 0, 0);
        chk("first_play_bx", ball_x, 314);
        chk("first_play_by", ball_y, 238);

        // Paddle follows the ball centre until five returns have been made
        guard = 0;
        while (m_hits < 5 && guard < 4000) begin
            target = m_by - 28;
            prev_hits = m_hits;
            do_tick(m_pad > target, m_pad < target, 0);
            if (prev_hits == 0 && m_hits == 1) begin
                chk("first_hit_bx", ball_x, 36);
                chk("first_hit_score", score, 1);
                chk("first_hit_pulse", last_hit, 1);
                chk("hit_clears", hit, 0);
            end
            guard++;
        end
        chk("rally_score", score, 5);
        chk("rally_sat_score", s_score, 3);
        chk("rally_lives", lives, 3);

        // Paddle runs away from the ball until the game is lost
        guard = 0;
        misses = 0;
        while (m_state != 3 && guard < 8000) begin
            prev_state = m_state;
            do_tick(m_by >= 240, m_by < 240, 0);
            guard++;
            if (prev_state == 1 && m_state == 2) begin
                misses++;
                if (misses == 1) begin
                    chk("miss1_lives", lives, 2);
                    chk("miss1_state", state, 2);
                end
                repeat (SERVE_FRAMES - 1) do_tick(0, 0, 0);
                chk("miss_hold_state", state, 2);
                do_tick(0, 0, 0);
                chk("reserve_state", state, 0);
                chk("reserve_bx", ball_x, 316);
                chk("reserve_by", ball_y, 236);
            end
        end
        chk("over_state", state, 3);
        chk("over_lives", lives, 0);

        pad_before = m_pad;
        repeat (5) do_tick(1, 0, 0);
        chk("over_pad_frozen", pad_y, pad_before);
        chk("over_state_held", state, 3);
        do_tick(0, 0, 1);
        chk("restart_score", score, 0);
        chk("restart_lives", lives, 3);
        chk("restart_state", state, 0);
        chk("restart_pad", pad_y, 208);

        do_tick(1, 0, 0);
        chk("pad_up_first", pad_y, 205);
        repeat (99) do_tick(1, 0, 0);
        chk("pad_up_clamp", pad_y, 0);
        chk("pad_play_state", state, 1);
        repeat (5) do_tick(1, 1, 1);
        chk("pad_both_hold", pad_y, 0);
        chk("start_ignored", state, 1);

        // Asynchronous reset pulse between frame ticks
        repeat (3) do_tick(0, 0, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        model_reset();
        #1 check_reset_values("async_reset");
        #2 reset = 1'b1;
        repeat (3) do_tick(0, 0, 0);
        chk("post_reset_state", state, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/puck_engine.md
Name: puck_engine

Overview:
- Parametrised successor to the fixed single-paddle puck game core.
- Owns all per-frame game state: paddle position, ball position and velocity, score, lives, and game phase.
- Updates once per frame on a vblank pulse.
- Sits between the debouncers/VGA timing and the pixel renderer; all geometry, speeds, score width and life count are parameters.

Parameters:
- H_RES, 640, visible width in pixels
- V_RES, 480, visible height in pixels
- BALL_SIZE, 8, ball edge length in pixels
- PAD_X, 32, paddle left edge x
- PAD_W, 4, paddle width
- PAD_H, 64, paddle height
- BALL_SPEED, 2, ball pixels per frame on each axis
- PAD_SPEED, 3, paddle pixels per frame
- SCORE_W, 16, score counter width
- LIVES, 3, lives per game (1..7)
- SERVE_FRAMES, 60, frames held in SERVE before launch

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse at vblank start
- up  in  1  debounced level, paddle up
- down  in  1  debounced level, paddle down
- start  in  1  debounced level, restarts game from OVER
- pad_y  out  10  paddle top y
- ball_x  out  10  ball left x
- ball_y  out  10  ball top y
- score  out  SCORE_W  paddle hits this game
- lives  out  3  remaining lives
- state  out  2  SERVE=0, PLAY=1, MISS=2, OVER=3
- hit  out  1  one-cycle pulse on paddle collision

Behaviour:
- Reset (reset low, asynchronous):
  - pad_y=(V_RES-PAD_H)/2; ball_x=(H_RES-BALL_SIZE)/2; ball_y=(V_RES-BALL_SIZE)/2
  - dx=-1, dy=+1; score=0; lives=LIVES; state=SERVE; frame counter=0; hit=0
- Update timing: all state changes only on the cycle frame_tick=1. Outputs are registered and the new values are visible the following cycle. No other cycle alters state. frame_tick is ignored while reset is low.
- Paddle (all states except OVER):
  - up&!down: pad_y -= PAD_SPEED, clamped at 0.
  - down&!up: pad_y += PAD_SPEED, clamped at V_RES-PAD_H.
  - Both or neither: hold.
- SERVE:
  - Ball held at centre. Counter increments per tick.
  - On the tick where counter==SERVE_FRAMES-1: counter clears, state->PLAY, dx=-1, dy keeps its prior sign.
- PLAY, per tick, signed arithmetic in 12 bits:
  - nx=ball_x+dx*BALL_SPEED; ny=ball_y+dy*BALL_SPEED.
  - ny<0: ball_y=0, dy=+1.
  - ny>V_RES-BALL_SIZE: ball_y=V_RES-BALL_SIZE, dy=-1.
  - nx>H_RES-BALL_SIZE: ball_x=H_RES-BALL_SIZE, dx=-1.
  - Paddle collision requires all of:
    - dx=-1
    - nx<=PAD_X+PAD_W-1
    - nx+BALL_SIZE>PAD_X
    - ny+BALL_SIZE>pad_y (pad_y is the pre-update value)
    - ny<pad_y+PAD_H
  - Collision result: ball_x=PAD_X+PAD_W, dx=+1, score+=1 saturating at 2^SCORE_W-1, hit=1 for one cycle.
  - Miss: nx<0 with no collision -> lives-=1, ball frozen. If lives was 1 -> OVER, else -> MISS.
  - Collision takes priority over miss in the same tick.
  - Y-axis and X-axis bounces are independent; a corner reflects both axes.
- MISS: hold ball for SERVE_FRAMES ticks, then recentre the ball and go to SERVE (counter cleared).
- OVER:
  - Ball and paddle frozen; score and lives held.
  - start=1 on a tick -> score=0, lives=LIVES, recentre ball and paddle, state->SERVE.
  - start outside OVER is ignored.
- hit deasserts the cycle after assertion, regardless of frame_tick.
- Reset asserted mid-frame or mid-collision: immediate return to reset values; no partial score update survives.

Decomposition:
- Package puck_pkg:
  - state encodings
  - direction constants DIR_POS/DIR_NEG
  - coordinate width (10) and signed work width (12)
- One sub-module, puck_axis:
  - step one coordinate by ±speed with low/high clamp and direction flip.
  - Instantiated for ball_x (high wall only; low edge handled by the collision/miss logic) and ball_y (both walls).
  - Paddle uses the same clamp logic without the flip.

Test Plan:
- Reset, then 60 ticks with no input: state SERVE->PLAY on tick 60; ball_x=316, ball_y=236 before launch; after the first PLAY tick, ball_x=314, ball_y=238.
- Hold up 100 ticks: pad_y goes 208->205->...->0, then stays 0. Hold up+down: pad_y unchanged.
- Ball placed so nx=35, ball_y within paddle span, dx=-1: next cycle ball_x=36, dx=+1, score 0->1, hit high exactly one cycle.
- Paddle moved away, ball reaches nx<0: lives 3->2, state MISS; after 60 ticks, state SERVE with the ball recentred.
- Three misses: lives=0, state OVER; ticks without start change nothing; start on a tick -> score=0, lives=3, state SERVE.
- Pulse reset low for 3 ns mid-PLAY between ticks: all outputs return to reset values asynchronously; score saturation check with SCORE_W=2 -> score stops at 3.
